alt_vipvfr131_common_fifo_ext: RTL

Single-clock, parametrised FIFO with inferred RAM and no vendor megafunction. Supersedes the scfifo path of the common FIFO wrapper for the frame reader and line buffers. Adds:
- selectable normal or show-ahead read mode
- arbitrary (non power-of-2) depth
- almost-full and almost-empty thresholds
- synchronous clear
- internal overflow/underflow protection with sticky error flags

---
 rtl/alt_vipvfr131_common_pkg.sv | 31 +++
 rtl/alt_vipvfr131_common_sdp_ram.sv | 27 ++
 rtl/alt_vipvfr131_common_fifo_ext.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/alt_vipvfr131_common_pkg.sv
// Shared types and elaboration-time helpers for the common FIFO blocks.
package alt_vipvfr131_common_pkg;

    // Show-ahead prefetch state of the output register.
    typedef enum logic [1:0] {
        PF_IDLE  = 2'd0,
        PF_FETCH = 2'd1,
        PF_VALID = 2'd2
    } pf_state_t;

    // Bits needed to index 'value' distinct items (minimum 1).
    function automatic int clogb2(input int value);
        int bits;
        bits = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'd1 << i) < 32'(value)) bits = i + 1;
        end
        return bits;
    endfunction

    // Highest legal pointer value for a buffer of 'depth' words.
    function automatic int ptr_last(input int depth);
        return depth - 1;
    endfunction

    // Pointer increment with explicit wrap, so non power-of-2 depths work.
    function automatic int ptr_next(input int ptr, input int last);
        return (ptr == last) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/alt_vipvfr131_common_sdp_ram.sv
// Simple dual-port inferred RAM: one write port, one read port with a
// single registered read stage.
module alt_vipvfr131_common_sdp_ram
    import alt_vipvfr131_common_pkg::*;
#(
    parameter int DATA_WIDTH = 20,
    parameter int FIFO_DEPTH = 1920,
    parameter int ADDR_WIDTH = clogb2(FIFO_DEPTH)
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    // Write port and registered read port; no reset so the array maps to block RAM.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/alt_vipvfr131_common_fifo_ext.sv
// Single-clock FIFO on inferred RAM with normal or show-ahead read, arbitrary
// depth, almost flags, synchronous clear and sticky overflow/underflow flags.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// PF_IDLE  | show-ahead output register empty and nothing stored in RAM
// PF_FETCH | RAM read in flight; head word lands on q next cycle
// PF_VALID | q holds the head word (empty = 0)
module alt_vipvfr131_common_fifo_ext
    import alt_vipvfr131_common_pkg::*;
#(
    parameter int DATA_WIDTH         = 20,
    parameter int FIFO_DEPTH         = 1920,
    parameter int SHOWAHEAD          = 0,
    parameter int ALMOST_FULL_LEVEL  = FIFO_DEPTH - 4,
    parameter int ALMOST_EMPTY_LEVEL = 4,
    parameter int USEDW_WIDTH        = clogb2(FIFO_DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   sclr,
    input  logic                   wrreq,
    input  logic [DATA_WIDTH-1:0]  data,
    input  logic                   rdreq,
    output logic [DATA_WIDTH-1:0]  q,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_empty,
    output logic                   almost_full,
    output logic [USEDW_WIDTH-1:0] usedw,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW   = clogb2(FIFO_DEPTH);
    localparam int LAST = ptr_last(FIFO_DEPTH);
    localparam logic [USEDW_WIDTH-1:0] DEPTH_U = USEDW_WIDTH'(FIFO_DEPTH);
    localparam logic [USEDW_WIDTH-1:0] AF_U    = USEDW_WIDTH'(ALMOST_FULL_LEVEL);
    localparam logic [USEDW_WIDTH-1:0] AE_U    = USEDW_WIDTH'(ALMOST_EMPTY_LEVEL);
    localparam logic [USEDW_WIDTH-1:0] ONE_U   = USEDW_WIDTH'(1);

    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [USEDW_WIDTH-1:0] usedw_nxt;
    logic [DATA_WIDTH-1:0]  ram_q, q_hold;
    logic                   empty_r, fresh;
    logic                   wr_acc, rd_acc, ram_rd;
    pf_state_t              state, state_nxt;

    alt_vipvfr131_common_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (data),
        .rd_en   (ram_rd),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    // q follows the RAM output in the cycle after a read, then holds.
    assign q     = fresh ? ram_q : q_hold;
    assign empty = (SHOWAHEAD != 0) ? (state != PF_VALID) : empty_r;

    // Accept/reject decisions, RAM read issue, prefetch next state and next count.
    always_comb begin
        state_nxt = state;
        wr_acc    = wrreq && !full && !sclr;
        rd_acc    = 1'b0;
        ram_rd    = 1'b0;
        if (SHOWAHEAD != 0) begin
            rd_acc = rdreq && (state == PF_VALID) && !sclr;
            case (state)
                PF_IDLE:  if (wr_acc) state_nxt = PF_FETCH;
                PF_FETCH: begin
                    ram_rd    = !sclr;
                    state_nxt = PF_VALID;
                end
                PF_VALID: begin
                    if (rd_acc) begin
                        // usedw counts the word on q, so >1 means RAM still holds one
                        if (usedw > ONE_U) begin
                            ram_rd    = 1'b1;
                            state_nxt = PF_VALID;
                        end else if (wr_acc) begin
                            state_nxt = PF_FETCH;
                        end else begin
                            state_nxt = PF_IDLE;
                        end
                    end
                end
                default:  state_nxt = PF_IDLE;
            endcase
            if (sclr) state_nxt = PF_IDLE;
        end else begin
            rd_acc = rdreq && !empty_r && !sclr;
            ram_rd = rd_acc;
        end

        usedw_nxt = usedw;
        if (wr_acc && !rd_acc)      usedw_nxt = usedw + ONE_U;
        else if (!wr_acc && rd_acc) usedw_nxt = usedw - ONE_U;
        if (sclr)                   usedw_nxt = '0;
    end

    // Prefetch state register.
    always_ff @(posedge clock) begin
        if (reset) state <= PF_IDLE;
        else       state <= state_nxt;
    end

    // Pointers, count, level flags, sticky errors and q hold register.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            usedw        <= '0;
            empty_r      <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            fresh        <= 1'b0;
            q_hold       <= '0;
        end else begin
            q_hold       <= q;
            fresh        <= ram_rd;
            usedw        <= usedw_nxt;
            empty_r      <= (usedw_nxt == '0);
            full         <= (usedw_nxt == DEPTH_U);
            almost_empty <= (usedw_nxt <= AE_U);
            almost_full  <= (usedw_nxt >= AF_U);
            if (wrreq && full && !sclr)  overflow  <= 1'b1;
            if (rdreq && empty && !sclr) underflow <= 1'b1;
            if (sclr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_acc) wr_ptr <= AW'(ptr_next(int'(wr_ptr), LAST));
                if (ram_rd) rd_ptr <= AW'(ptr_next(int'(rd_ptr), LAST));
            end
        end
    end

endmodule
